// File: rtl/cursor_pkg.sv
// Shared constants, FSM state type and clamp/saturate helpers for the cursor
// report transmitter.
package cursor_pkg;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam int unsigned PKT_BYTES = 4;
    localparam int          DELTA_MAX = 127;
    localparam int          ACC_MAX   = 32767;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    // Symmetric clamp: -128 is never produced, so a packet byte is always negatable.
    function automatic logic [7:0] clamp_delta(input logic signed [15:0] v);
        int vi;
        vi = int'(v);
        if (vi > DELTA_MAX) begin
            vi = DELTA_MAX;
        end else if (vi < -DELTA_MAX) begin
            vi = -DELTA_MAX;
        end
        return 8'(vi);
    endfunction

    function automatic logic [15:0] sat_acc(input logic signed [17:0] v);
        int vi;
        vi = int'(v);
        if (vi > ACC_MAX) begin
            vi = ACC_MAX;
        end else if (vi < -ACC_MAX) begin
            vi = -ACC_MAX;
        end
        return 16'(vi);
    endfunction

    function automatic logic acc_clipped(input logic signed [17:0] v);
        return (int'(v) > ACC_MAX) || (int'(v) < -ACC_MAX);
    endfunction

endpackage

// File: rtl/cursor_report_tx_if.sv
// Delta input strobe plus UART/status outputs of the cursor report transmitter.
interface cursor_report_tx_if;

    logic       in_valid;
    logic [7:0] dx_in;
    logic [7:0] dy_in;
    logic       tx;
    logic       busy;
    logic       pkt_sent;
    logic       acc_sat;

    modport master (
        output in_valid, dx_in, dy_in,
        input  tx, busy, pkt_sent, acc_sat
    );

    modport slave (
        input  in_valid, dx_in, dy_in,
        output tx, busy, pkt_sent, acc_sat
    );

endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: bit timer plus frame shifter; a start in the done cycle
// chains the next frame with no idle gap.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_data,
    output logic       o_tx,
    output logic       o_bit_end,
    output logic       o_done
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic          r_active;
    logic          r_tx;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bits;
    logic [8:0]    r_shift;
    logic          w_bit_end;

    assign w_bit_end = r_active && (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign o_bit_end = w_bit_end;
    assign o_done    = w_bit_end && (r_bits == 4'd9);
    assign o_tx      = r_tx;

    // r_bits counts completed bits: 0 = start, 1..8 = data, 9 = stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_shift  <= '1;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_tx     <= 1'b0;
            r_cnt    <= '0;
            r_bits   <= '0;
            r_shift  <= {1'b1, i_data};
        end else if (r_active) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_bits == 4'd9) begin
                    r_active <= 1'b0;
                end else begin
                    r_tx    <= r_shift[0];
                    r_shift <= {1'b1, r_shift[8:1]};
                    r_bits  <= r_bits + 4'd1;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cursor_report_tx.sv
// Accumulates signed cursor deltas and, once per report period, sends a
// 4-byte packet (sync, dx, dy, checksum) over UART 8N1.
module cursor_report_tx
    import cursor_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned REPORT_DIV   = 1000000,
    parameter bit          SEND_ZERO    = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    cursor_report_tx_if.slave bus
);

    localparam int unsigned TW = (REPORT_DIV > 1) ? $clog2(REPORT_DIV) : 1;

    state_t             r_state, w_state_next;
    logic [TW-1:0]      r_tick_cnt;
    logic               w_tick;
    logic               r_pend;
    logic signed [15:0] r_acc_x, r_acc_y;
    logic signed [17:0] w_sum_x, w_sum_y;
    logic signed [7:0]  w_sx, w_sy;
    logic [7:0]         r_sx, r_sy;
    logic [7:0]         w_in_x, w_in_y;
    logic               r_acc_sat;
    logic               r_pkt_sent;
    logic [1:0]         r_byte_idx, w_byte_idx_next;
    logic [2:0]         r_bit_idx, w_bit_idx_next;
    logic               w_consume, w_latch, w_start, w_pkt_done, w_skip;
    logic [7:0]         w_data, w_next_byte;
    logic               w_tx, w_bit_end, w_done;

    assign w_tick = (r_tick_cnt == TW'(REPORT_DIV - 1));
    assign w_skip = !SEND_ZERO && (r_acc_x == '0) && (r_acc_y == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
            r_pend     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_pend     <= (r_pend | w_tick) & ~w_consume;
        end
    end

    // The latch subtracts the sent amount and adds a same-cycle sample in one step.
    assign w_sx    = w_latch ? clamp_delta(r_acc_x) : '0;
    assign w_sy    = w_latch ? clamp_delta(r_acc_y) : '0;
    assign w_in_x  = bus.in_valid ? bus.dx_in : '0;
    assign w_in_y  = bus.in_valid ? bus.dy_in : '0;
    assign w_sum_x = {{2{r_acc_x[15]}}, r_acc_x} - {{10{w_sx[7]}}, w_sx} + {{10{w_in_x[7]}}, w_in_x};
    assign w_sum_y = {{2{r_acc_y[15]}}, r_acc_y} - {{10{w_sy[7]}}, w_sy} + {{10{w_in_y[7]}}, w_in_y};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_acc_sat <= 1'b0;
            r_sx      <= '0;
            r_sy      <= '0;
        end else begin
            r_acc_x   <= sat_acc(w_sum_x);
            r_acc_y   <= sat_acc(w_sum_y);
            r_acc_sat <= r_acc_sat | acc_clipped(w_sum_x) | acc_clipped(w_sum_y);
            if (w_latch) begin
                r_sx <= w_sx;
                r_sy <= w_sy;
            end
        end
    end

    always_comb begin
        unique case (r_byte_idx)
            2'd0:    w_next_byte = r_sx;
            2'd1:    w_next_byte = r_sy;
            default: w_next_byte = SYNC_BYTE ^ r_sx ^ r_sy;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_pkt_sent <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_byte_idx_next;
            r_bit_idx  <= w_bit_idx_next;
            r_pkt_sent <= w_pkt_done;
        end
    end

    // Tick is looked at directly in IDLE so LOAD follows it by one cycle.
    always_comb begin
        w_state_next    = r_state;
        w_byte_idx_next = r_byte_idx;
        w_bit_idx_next  = r_bit_idx;
        w_consume       = 1'b0;
        w_latch         = 1'b0;
        w_start         = 1'b0;
        w_data          = SYNC_BYTE;
        w_pkt_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_pend || w_tick) begin
                    w_consume = 1'b1;
                    if (!w_skip) begin
                        w_state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                w_latch         = 1'b1;
                w_start         = 1'b1;
                w_byte_idx_next = '0;
                w_state_next    = START;
            end
            START: begin
                if (w_bit_end) begin
                    w_bit_idx_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (w_done) begin
                    if (r_byte_idx < 2'(PKT_BYTES - 1)) begin
                        w_start         = 1'b1;
                        w_data          = w_next_byte;
                        w_byte_idx_next = r_byte_idx + 2'd1;
                        w_state_next    = START;
                    end else begin
                        w_pkt_done   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_start),
        .i_data   (w_data),
        .o_tx     (w_tx),
        .o_bit_end(w_bit_end),
        .o_done   (w_done)
    );

    assign bus.tx       = w_tx;
    assign bus.busy     = (r_state != IDLE);
    assign bus.pkt_sent = r_pkt_sent;
    assign bus.acc_sat  = r_acc_sat;

endmodule

// File: tb/tb_cursor_report_tx.sv
// Self-checking bench for cursor_report_tx: accumulator model feeds a byte
// scoreboard, a UART decoder on tx pops and compares.
module tb_cursor_report_tx;

    localparam int unsigned CPB = 4;
    localparam int unsigned DIV = 400;
    localparam int          PKT_CYCLES = 40 * CPB;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cursor_report_tx_if bus ();

    cursor_report_tx #(
        .CLKS_PER_BIT(CPB),
        .REPORT_DIV  (DIV),
        .SEND_ZERO   (1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_i(input int v, input int lim);
        return (v > lim) ? lim : ((v < -lim) ? -lim : v);
    endfunction

    // Reference model state
    int mx = 0, my = 0;
    bit msat = 0;
    int exp_q[$];
    int rx_pkts[$];
    bit prev_busy = 0;
    int busy_len = 0;
    int load_cyc = 0;
    int n_loads = 0;

    function automatic int pkt_at(input int i);
        if (i < rx_pkts.size()) return rx_pkts[i];
        return -1;
    endfunction

    initial begin
        int ix, iy, sx, sy, nx, ny;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mx = 0; my = 0; msat = 0;
                exp_q.delete();
                prev_busy = 0;
                busy_len = 0;
            end else begin
                ix = bus.in_valid ? int'($signed(bus.dx_in)) : 0;
                iy = bus.in_valid ? int'($signed(bus.dy_in)) : 0;
                sx = 0;
                sy = 0;
                if (bus.busy && !prev_busy) begin
                    sx = clamp_i(mx, 127);
                    sy = clamp_i(my, 127);
                    exp_q.push_back(165);
                    exp_q.push_back(sx & 255);
                    exp_q.push_back(sy & 255);
                    exp_q.push_back(165 ^ (sx & 255) ^ (sy & 255));
                    load_cyc = cyc;
                    n_loads++;
                end
                nx = mx - sx + ix;
                ny = my - sy + iy;
                if (nx != clamp_i(nx, 32767) || ny != clamp_i(ny, 32767)) msat = 1;
                mx = clamp_i(nx, 32767);
                my = clamp_i(ny, 32767);
                if (bus.busy) busy_len++;
                if (prev_busy && !bus.busy) begin
                    check("busy_len", busy_len, PKT_CYCLES + 1);
                    check("pkt_sent_at_busy_fall", int'(bus.pkt_sent), 1);
                    busy_len = 0;
                end else if (bus.pkt_sent) begin
                    check("pkt_sent_stray", int'(bus.pkt_sent), 0);
                end
                prev_busy = bus.busy;
            end
        end
    end

    // UART decoder
    bit         dec_active = 0;
    int         dec_cnt = 0;
    int         dec_nbytes = 0;
    logic [7:0] dec_byte;
    logic [31:0] cur_pkt;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                dec_active = 0;
                dec_cnt = 0;
                dec_nbytes = 0;
                cur_pkt = '0;
            end else if (!dec_active) begin
                if (bus.tx == 1'b0) begin
                    dec_active = 1;
                    dec_cnt = 0;
                    dec_byte = '0;
                    if (dec_nbytes == 0) check("load_to_start", cyc - load_cyc, 1);
                end
            end else begin
                dec_cnt++;
                if ((dec_cnt % CPB) == CPB / 2 && dec_cnt / CPB >= 1 && dec_cnt / CPB <= 8)
                    dec_byte[dec_cnt / CPB - 1] = bus.tx;
                if (dec_cnt == 9 * CPB + CPB / 2) begin
                    check("stop_bit", int'(bus.tx), 1);
                    dec_active = 0;
                    if (exp_q.size() == 0)
                        check("unexpected_byte", int'(dec_byte), 256);
                    else
                        check($sformatf("byte%0d", dec_nbytes), int'(dec_byte), exp_q.pop_front());
                    cur_pkt = {cur_pkt[23:0], dec_byte};
                    dec_nbytes++;
                    if (dec_nbytes == 4) begin
                        rx_pkts.push_back(int'(cur_pkt));
                        dec_nbytes = 0;
                    end
                end
            end
        end
    end

    task automatic drive(input int n, input int dx, input int dy);
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.dx_in    = 8'(dx);
            bus.dy_in    = 8'(dy);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.dx_in    = '0;
        bus.dy_in    = '0;
    endtask

    task automatic wait_drain(input int bound);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(posedge clk); #1;
            ok = (exp_q.size() == 0) && !dec_active && !bus.busy;
        end
        check("drain", int'(ok), 1);
    endtask

    task automatic wait_load(input int bound, output bit seen);
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus.busy;
        end
        check("load_seen", int'(seen), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.dx_in    = '0;
        bus.dy_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", int'(bus.tx), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_pkt_sent", int'(bus.pkt_sent), 0);
        check("rst_acc_sat", int'(bus.acc_sat), 0);
        rst_n = 1'b1;

        // Zero motion: ticks must be skipped
        repeat (1000) @(posedge clk);
        #1;
        check("idle_no_packets", n_loads, 0);
        check("idle_tx", int'(bus.tx), 1);

        // Ten samples of (+5, -3)
        base = rx_pkts.size();
        drive(10, 5, -3);
        repeat (DIV + 20) @(posedge clk);
        wait_drain(400);
        check("pkt_a_count", rx_pkts.size() - base, 1);
        check("pkt_a", pkt_at(base), 32'hA532E275);

        // +300 carried over three reports
        base = rx_pkts.size();
        drive(3, 100, 0);
        repeat (3 * DIV + 50) @(posedge clk);
        wait_drain(600);
        check("carry_count", rx_pkts.size() - base, 3);
        check("carry_pkt0", pkt_at(base), 32'hA57F00DA);
        check("carry_pkt1", pkt_at(base + 1), 32'hA57F00DA);
        check("carry_pkt2", pkt_at(base + 2), 32'hA52E008B);

        // Sample arriving in the latch cycle goes to the next report
        base = rx_pkts.size();
        drive(1, 10, 0);
        wait_load(DIV + 20, seen);
        drive(1, 2, 0);
        wait_drain(400);
        repeat (DIV + 20) @(posedge clk);
        wait_drain(400);
        check("latch_count", rx_pkts.size() - base, 2);
        check("latch_pkt0", pkt_at(base), 32'hA50A00AF);
        check("latch_pkt1", pkt_at(base + 1), 32'hA50200A7);

        // Saturation
        drive(400, 100, 0);
        check("sat_flag", int'(bus.acc_sat), 1);
        check("sat_model_flag", int'(msat), 1);
        check("sat_acc_x", int'($signed(dut.r_acc_x)), mx);
        repeat (DIV) @(posedge clk);
        #1;
        check("sat_sticky", int'(bus.acc_sat), 1);
        check("sat_acc_x_later", int'($signed(dut.r_acc_x)), mx);

        // Reset during the start bit of the second byte
        wait_drain(400);
        wait_load(DIV + 20, seen);
        repeat (1 + 10 * CPB + 1) @(posedge clk);
        #2;
        check("pre_rst_tx_low", int'(bus.tx), 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx", int'(bus.tx), 1);
        check("mid_rst_busy", int'(bus.busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_acc_sat", int'(bus.acc_sat), 0);
        check("mid_rst_acc_x", int'($signed(dut.r_acc_x)), 0);
        rst_n = 1'b1;
        base = rx_pkts.size();
        drive(1, 7, 9);
        repeat (DIV + 20) @(posedge clk);
        wait_drain(400);
        check("post_rst_count", rx_pkts.size() - base, 1);
        check("post_rst_pkt", pkt_at(base), 32'hA50709AB);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
